ipv4_rx: RTL and testbench

IPV4_RX -- requirements
Module: ipv4_rx

---
 rtl/ipv4_pkg.sv | 19 +
 rtl/ipv4_if.sv | 33 +++
 rtl/ipv4_csum.sv | 37 +++
 rtl/ipv4_rx.sv | 155 +++++++++++++++
 tb/tb_ipv4_rx.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipv4_pkg.sv
// rtl/ipv4_pkg.sv - shared types and constants for the IPv4 receive parser
// Purpose: FSM state type and IPv4 header constants used by ipv4_rx and its bench.
// Ports: none (package).
package ipv4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEAD,
      OPT,
      DATA,
      DROP
   } state_t;

   localparam logic [3:0] IPV4_VER   = 4'd4;
   localparam logic [3:0] IHL_MIN    = 4'd5;
   localparam logic [7:0] PROTO_UDP  = 8'd17;
   localparam logic [4:0] HEAD_WORDS = 5'd10;

endpackage

// File: rtl/ipv4_if.sv
// rtl/ipv4_if.sv - word stream bundle between MAC RX, the IPv4 parser and the UDP stage
// Purpose: groups the upstream (*_i) and downstream (*_o) stream signals.
// Ports (modports):
//   master - MAC/UDP side: drives valid_i/start_i/term_i/data_i/len_i/cancel_i, observes *_o
//   slave  - parser side: observes *_i, drives valid_o/start_o/term_o/data_o/len_o/cancel_o
interface ipv4_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2
);
   logic              valid_i;
   logic              start_i;
   logic              term_i;
   logic [DATA_W-1:0] data_i;
   logic [LEN_W-1:0]  len_i;
   logic              cancel_i;

   logic              valid_o;
   logic              start_o;
   logic              term_o;
   logic [DATA_W-1:0] data_o;
   logic [LEN_W-1:0]  len_o;
   logic              cancel_o;

   modport master (
      output valid_i, start_i, term_i, data_i, len_i, cancel_i,
      input  valid_o, start_o, term_o, data_o, len_o, cancel_o
   );

   modport slave (
      input  valid_i, start_i, term_i, data_i, len_i, cancel_i,
      output valid_o, start_o, term_o, data_o, len_o, cancel_o
   );
endinterface

// File: rtl/ipv4_csum.sv
// rtl/ipv4_csum.sv - 16-bit ones-complement (end-around carry) accumulator
// Purpose: running IPv4 header checksum; sum shows the total including the word on data.
// Ports:
//   clk, nreset - clock, asynchronous active-low reset
//   clr         - start a new sum with this word (ignores the stored total)
//   add         - accumulate data into the stored total
//   data        - 16-bit word to add
//   sum         - combinational total including data
module ipv4_csum (
   input  logic        clk,
   input  logic        nreset,
   input  logic        clr,
   input  logic        add,
   input  logic [15:0] data,
   output logic [15:0] sum
);

   logic [15:0] acc;
   logic [15:0] base;
   logic [16:0] raw;

   // The folded carry cannot overflow again: max raw is 0x1FFFE -> 0xFFFF.
   always_comb begin
      base = clr ? 16'd0 : acc;
      raw  = {1'b0, base} + {1'b0, data};
      sum  = raw[15:0] + {15'd0, raw[16]};
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         acc <= 16'd0;
      end else if (add) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/ipv4_rx.sv
// rtl/ipv4_rx.sv - IPv4 header parser between the MAC RX stage and the UDP stage
// Purpose: checks and strips the IPv4 header, forwards the UDP payload with zero
//   latency, trims Ethernet padding and flags bad/truncated datagrams.
// Configuration: IPV4_CHECKSUM_EN adds header checksum verification.
// Ports:
//   clk        - clock
//   nreset     - asynchronous active-low reset
//   bus        - ipv4_if.slave: MAC stream in (*_i), UDP stream out (*_o)
//   src_addr_o - latched source address
//   dst_addr_o - latched destination address
module ipv4_rx
   import ipv4_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 2
) (
   input  logic        clk,
   input  logic        nreset,
   ipv4_if.slave       bus,
   output logic [31:0] src_addr_o,
   output logic [31:0] dst_addr_o
);

   state_t            state;
   logic [4:0]        cnt;
   logic [3:0]        ihl;
   logic [15:0]       remaining;
   logic              first;

   logic [DATA_W-1:0] w;
   logic [4:0]        opt_words;
   logic              word0_ok;
   logic              hdr_last;
   logic              hdr_bad;
   logic              csum_ok;
   logic              live;
   logic              pay;
   logic              last;
   logic              unused_len;

   assign w          = bus.data_i;
   assign unused_len = ^bus.len_i;

`ifdef IPV4_CHECKSUM_EN
   logic [15:0] csum_sum;

   ipv4_csum u_csum (
      .clk    (clk),
      .nreset (nreset),
      .clr    (bus.start_i),
      .add    (bus.valid_i & ~bus.cancel_i &
               (bus.start_i | (state == HEAD) | (state == OPT))),
      .data   (w),
      .sum    (csum_sum)
   );

   // A correct header, checksum field included, sums to all ones.
   assign csum_ok = (csum_sum == 16'hFFFF);
`else
   assign csum_ok = 1'b1;
`endif

   always_comb begin
      opt_words = {ihl - IHL_MIN, 1'b0};
      word0_ok  = (w[15:12] == IPV4_VER) && (w[11:8] >= IHL_MIN);
      hdr_last  = ((state == HEAD) && (cnt == HEAD_WORDS - 5'd1) && (ihl == IHL_MIN)) ||
                  ((state == OPT) && (cnt == opt_words - 5'd1));
      hdr_bad   = ((state == HEAD) && (cnt == 5'd1) && (w < {10'd0, ihl, 2'b00})) ||
                  ((state == HEAD) && (cnt == 5'd4) && (w[7:0] != PROTO_UDP)) ||
                  (hdr_last && !csum_ok);
   end

   // Payload path is combinational; gating with nreset keeps outputs quiet during reset.
   always_comb begin
      live         = nreset & bus.valid_i;
      pay          = live & (state == DATA) & ~bus.cancel_i & ~bus.start_i;
      last         = (remaining <= 16'd2);
      bus.valid_o  = pay;
      bus.start_o  = pay & first;
      bus.term_o   = pay & last;
      bus.len_o    = last ? remaining[LEN_W-1:0] : LEN_W'(2);
      bus.data_o   = bus.data_i;
      bus.cancel_o = live & (bus.cancel_i |
                     ((state == DATA) & (bus.start_i | (bus.term_i & ~last))));
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state      <= IDLE;
         cnt        <= 5'd0;
         ihl        <= 4'd0;
         remaining  <= 16'd0;
         first      <= 1'b0;
         src_addr_o <= 32'd0;
         dst_addr_o <= 32'd0;
      end else if (bus.valid_i) begin
         if (bus.cancel_i) begin
            state <= IDLE;
            cnt   <= 5'd0;
            first <= 1'b0;
         end else if (bus.start_i) begin
            // A start word always begins a fresh header, whatever was in flight.
            ihl   <= w[11:8];
            cnt   <= 5'd1;
            first <= 1'b0;
            state <= word0_ok ? HEAD : DROP;
         end else begin
            case (state)
               HEAD, OPT: begin
                  cnt <= cnt + 5'd1;
                  if (state == HEAD) begin
                     case (cnt)
                        5'd1: remaining <= w - {10'd0, ihl, 2'b00};
                        5'd6: src_addr_o[31:16] <= w;
                        5'd7: src_addr_o[15:0]  <= w;
                        5'd8: dst_addr_o[31:16] <= w;
                        5'd9: dst_addr_o[15:0]  <= w;
                        default: ;
                     endcase
                  end
                  if (bus.term_i) begin
                     state <= IDLE;
                  end else if (hdr_bad) begin
                     state <= DROP;
                  end else if (hdr_last) begin
                     // Empty payload: nothing to forward, just wait for the frame end.
                     state <= (remaining == 16'd0) ? DROP : DATA;
                     first <= 1'b1;
                  end else if ((state == HEAD) && (cnt == HEAD_WORDS - 5'd1)) begin
                     state <= OPT;
                     cnt   <= 5'd0;
                  end
               end
               DATA: begin
                  first     <= 1'b0;
                  remaining <= last ? 16'd0 : remaining - 16'd2;
                  if (last) begin
                     // Frame continuing past the datagram is Ethernet padding.
                     state <= bus.term_i ? IDLE : DROP;
                  end else if (bus.term_i) begin
                     state <= IDLE;
                  end
               end
               DROP: begin
                  if (bus.term_i) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ipv4_rx.sv
// tb/tb_ipv4_rx.sv - self-checking bench for ipv4_rx
module tb_ipv4_rx;

`ifdef IPV4_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] d;
      bit          s;
      bit          t;
      bit          c;
   } tx_t;

   typedef struct {
      logic [15:0] d;
      bit          s;
      bit          t;
      logic [1:0]  l;
   } rx_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;

   ipv4_if #(.DATA_W(16), .LEN_W(2)) bus ();

   ipv4_rx #(.DATA_W(16), .LEN_W(2)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .bus        (bus),
      .src_addr_o (src_addr),
      .dst_addr_o (dst_addr)
   );

   always #5 clk = ~clk;

   tx_t         tx[$];
   rx_t         exp_q[$];
   rx_t         got_q[$];
   int          exp_cancel = 0;
   int          got_cancel = 0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_src;
   logic [31:0] exp_dst;
   bit          addr_chk = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // valid_i low with random control levels: everything else must be ignored.
   task automatic drive_idle();
      bus.valid_i  = 1'b0;
      bus.start_i  = 1'($urandom);
      bus.term_i   = 1'($urandom);
      bus.cancel_i = 1'($urandom);
      bus.data_i   = 16'($urandom);
      bus.len_i    = 2'($urandom);
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.valid_o === 1'b1)
         got_q.push_back('{bus.data_o, bus.start_o, bus.term_o, bus.len_o});
      if (bus.cancel_o === 1'b1)
         got_cancel++;
      @(posedge clk);
      #1;
   endtask

   // Reference: builds one frame and states what the UDP side should see,
   // straight from the header rules (payload bytes = total_len - 4*IHL).
   // mode 0 complete(+pad), 1 cancel_i after k payload words, 2 term_i on word k,
   // 3 stop after k words (next start_i cancels), 4 stop after k words (no cancel).
   task automatic build_frame(input int ver, input int ihl, input int tlen, input int proto,
                              input bit bad_csum, input int pad, input int mode, input int k);
      logic [15:0] h[$];
      logic [31:0] s;
      logic [31:0] d;
      int unsigned acc;
      int          n;
      int          nw;
      int          pw;
      bit          ok;
      bit          lst;
      logic [15:0] pd;
      s = $urandom;
      d = $urandom;
      h.push_back({4'(ver), 4'(ihl), 8'h00});
      h.push_back(16'(tlen));
      h.push_back(16'($urandom));
      h.push_back(16'h4000);
      h.push_back({8'h40, 8'(proto)});
      h.push_back(16'h0000);
      h.push_back(s[31:16]);
      h.push_back(s[15:0]);
      h.push_back(d[31:16]);
      h.push_back(d[15:0]);
      for (int i = 0; i < (ihl - 5) * 2; i++) h.push_back(16'($urandom));
      acc = 0;
      foreach (h[i]) acc += h[i];
      while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
      h[5] = ~acc[15:0];
      if (bad_csum) h[5] = h[5] ^ 16'h00FF;

      ok = (ver == 4) && (ihl >= 5) && (proto == 17) && (tlen >= ihl * 4) &&
           !(bad_csum && CSUM_EN);
      n  = tlen - ihl * 4;
      nw = (n > 0) ? (n + 1) / 2 : 0;
      pw = (mode == 0) ? nw + pad : k;

      foreach (h[i]) tx.push_back('{h[i], (i == 0), 1'b0, 1'b0});
      if (mode == 0 && pw == 0) tx[tx.size() - 1].t = 1'b1;
      for (int i = 0; i < pw; i++) begin
         pd  = 16'($urandom);
         lst = (mode == 0 || mode == 2) && (i == pw - 1);
         tx.push_back('{pd, 1'b0, lst, 1'b0});
         if (ok && (mode != 0 || i < nw)) begin
            if (mode == 0 && i == nw - 1)
               exp_q.push_back('{pd, (i == 0), 1'b1, 2'(n - 2 * (nw - 1))});
            else
               exp_q.push_back('{pd, (i == 0), 1'b0, 2'd2});
         end
      end
      if (mode == 1) begin
         tx.push_back('{16'($urandom), 1'b0, 1'b0, 1'b1});
         exp_cancel++;
      end
      if (ok && (mode == 2 || mode == 3)) exp_cancel++;
      addr_chk = ok && (mode == 0);
      if (addr_chk) begin
         exp_src = s;
         exp_dst = d;
      end
   endtask

   task automatic send_all();
      foreach (tx[i]) begin
         repeat ($urandom_range(0, 2)) begin
            drive_idle();
            tick();
         end
         bus.valid_i  = 1'b1;
         bus.start_i  = tx[i].s;
         bus.term_i   = tx[i].t;
         bus.cancel_i = tx[i].c;
         bus.data_i   = tx[i].d;
         bus.len_i    = 2'd2;
         tick();
      end
      drive_idle();
      tick();
      tick();
      tx.delete();
   endtask

   task automatic compare(input string tag);
      check($sformatf("%s words", tag), got_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got_q.size()) begin
            check($sformatf("%s w%0d data", tag, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s w%0d start", tag, i), got_q[i].s, exp_q[i].s);
            check($sformatf("%s w%0d term", tag, i), got_q[i].t, exp_q[i].t);
            check($sformatf("%s w%0d len", tag, i), got_q[i].l, exp_q[i].l);
         end
      end
      check($sformatf("%s cancels", tag), got_cancel, exp_cancel);
      if (addr_chk) begin
         check($sformatf("%s src", tag), src_addr, exp_src);
         check($sformatf("%s dst", tag), dst_addr, exp_dst);
      end
      exp_q.delete();
      got_q.delete();
      exp_cancel = 0;
      got_cancel = 0;
      addr_chk   = 1'b0;
   endtask

   initial begin
      int ihl;
      int n;
      int nw;
      int proto;
      bit bad;
      int pad;
      int mode;
      int k;

      nreset = 1'b0;
      drive_idle();
      bus.valid_i  = 1'b1;
      bus.cancel_i = 1'b1;
      bus.term_i   = 1'b1;
      @(negedge clk);
      check("rst valid_o", bus.valid_o, 1'b0);
      check("rst start_o", bus.start_o, 1'b0);
      check("rst term_o", bus.term_o, 1'b0);
      check("rst cancel_o", bus.cancel_o, 1'b0);
      check("rst src", src_addr, 32'd0);
      check("rst dst", dst_addr, 32'd0);
      @(posedge clk);
      #1;
      drive_idle();
      nreset = 1'b1;
      tick();

      build_frame(4, 5, 'h1D, 17, 1'b0, 0, 0, 0);
      send_all();
      compare("good20");

      build_frame(4, 5, 'h1D, 17, 1'b1, 0, 0, 0);
      send_all();
      compare("badcsum");

      build_frame(4, 5, 'h1D, 6, 1'b0, 1, 0, 0);
      build_frame(4, 5, 'h1D, 17, 1'b0, 0, 0, 0);
      send_all();
      compare("tcp");

      build_frame(4, 6, 'h20, 17, 1'b0, 0, 0, 0);
      send_all();
      compare("ihl6");

      build_frame(4, 5, 'h1C, 17, 1'b0, 9, 0, 0);
      send_all();
      compare("padding");

      build_frame(4, 5, 'h1D, 17, 1'b0, 0, 1, 1);
      build_frame(4, 5, 'h1D, 17, 1'b0, 0, 0, 0);
      send_all();
      compare("cancel");

      build_frame(4, 5, 40, 17, 1'b0, 0, 2, 3);
      send_all();
      compare("trunc");

      build_frame(4, 5, 40, 17, 1'b0, 0, 3, 2);
      build_frame(4, 7, 30, 17, 1'b0, 1, 0, 0);
      send_all();
      compare("restart");

      build_frame(6, 5, 30, 17, 1'b0, 0, 0, 0);
      build_frame(4, 4, 30, 17, 1'b0, 0, 0, 0);
      build_frame(4, 5, 16, 17, 1'b0, 2, 0, 0);
      send_all();
      compare("badhdr");

      for (int f = 0; f < 30; f++) begin
         ihl   = $urandom_range(5, 7);
         n     = $urandom_range(1, 20);
         nw    = (n + 1) / 2;
         proto = ($urandom_range(0, 9) == 0) ? 6 : 17;
         bad   = ($urandom_range(0, 4) == 0);
         pad   = $urandom_range(0, 2);
         mode  = 0;
         k     = 0;
         if (nw >= 2 && $urandom_range(0, 3) == 0) begin
            mode = $urandom_range(1, 2);
            k    = (mode == 1) ? $urandom_range(0, nw - 1) : $urandom_range(1, nw - 1);
         end
         build_frame(4, ihl, ihl * 4 + n, proto, bad, pad, mode, k);
         send_all();
         compare($sformatf("rand%0d", f));
      end

      build_frame(4, 5, 40, 17, 1'b0, 0, 4, 3);
      send_all();
      compare("midrst pre");
      bus.valid_i  = 1'b1;
      bus.start_i  = 1'b0;
      bus.cancel_i = 1'b0;
      bus.term_i   = 1'b1;
      bus.data_i   = 16'($urandom);
      nreset       = 1'b0;
      @(negedge clk);
      check("midrst term_o", bus.term_o, 1'b0);
      check("midrst cancel_o", bus.cancel_o, 1'b0);
      check("midrst valid_o", bus.valid_o, 1'b0);
      check("midrst src", src_addr, 32'd0);
      @(posedge clk);
      #1;
      drive_idle();
      nreset = 1'b1;
      tick();
      build_frame(4, 5, 'h1D, 17, 1'b0, 1, 0, 0);
      send_all();
      compare("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
